// File: rtl/display_link_pkg.sv
// Shared state encoding and SPI idle levels for the display link transmitter.
package display_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/display_link_baud.sv
// SCLK generator: divides clk by ClkDiv per half-period and flags each toggle.
module display_link_baud
  import display_link_pkg::*;
#(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_run,
  output logic o_sclk,
  output logic o_tick_c
);

  localparam int unsigned DivW = $clog2(ClkDiv) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  logic [DivW-1:0] r_div;
  logic            r_sclk;

  // Tick marks the clk edge on which SCLK toggles.
  assign o_tick_c = i_run && (r_div == DivLast);
  assign o_sclk   = r_sclk;

  // Divider and SCLK; clear forces both back to their idle values.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_div  <= '0;
      r_sclk <= SCLK_IDLE;
    end else if (i_run) begin
      if (o_tick_c) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div <= r_div + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/display_link_tx.sv
// Snapshots DisplayBuffer once per frame and shifts it out MSB first over SCLK/MOSI/CS_N.
module display_link_tx
  import display_link_pkg::*;
#(
  parameter int unsigned DisplayBufferSize = 256,
  parameter int unsigned ClkDiv            = 4,
  parameter int unsigned FrameGap          = 16
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic [DisplayBufferSize-1:0] DisplayBuffer,
  input  logic                         Enable,
  output logic                         SCLK,
  output logic                         MOSI,
  output logic                         CS_N,
  output logic                         Busy,
  output logic                         FrameDone
);

  localparam int unsigned BitW = $clog2(DisplayBufferSize);
  localparam int unsigned GapW = $clog2(FrameGap) + 1;
  // The MSB goes straight to MOSI at load, so the shadow only holds the remaining bits.
  localparam int unsigned ShW  = DisplayBufferSize - 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DisplayBufferSize - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(FrameGap - 1);

  state_t          r_state,   w_state_nxt;
  logic [ShW-1:0]  r_shadow,  w_shadow_nxt;
  logic [BitW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [GapW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic            r_mosi,    w_mosi_nxt;
  logic            r_cs_n,    w_cs_n_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;

  logic w_load;
  logic w_sclk;
  logic w_tick_c;
  logic w_fall;
  logic w_baud_clear;

  assign w_fall       = w_tick_c & w_sclk;
  assign w_baud_clear = ~RESET | w_load;

  display_link_baud #(
    .ClkDiv (ClkDiv)
  ) u_baud (
    .clk      (clk),
    .i_clear  (w_baud_clear),
    .i_run    (r_state == ST_SHIFT),
    .o_sclk   (w_sclk),
    .o_tick_c (w_tick_c)
  );

  // Next-state and output logic; a frame load can start from IDLE or the last gap cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Enable) w_load = 1'b1;
      end
      ST_SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == BitLast) begin
            w_cs_n_nxt    = CS_N_IDLE;
            w_busy_nxt    = 1'b0;
            w_mosi_nxt    = MOSI_IDLE;
            w_done_nxt    = 1'b1;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = ST_GAP;
          end else begin
            w_shadow_nxt  = {r_shadow[ShW-2:0], 1'b0};
            w_mosi_nxt    = r_shadow[ShW-1];
            w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GapLast) begin
          if (Enable) begin
            w_load = 1'b1;
          end else begin
            w_gap_cnt_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GapW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_shadow_nxt  = DisplayBuffer[ShW-1:0];
      w_mosi_nxt    = DisplayBuffer[DisplayBufferSize-1];
      w_cs_n_nxt    = 1'b0;
      w_busy_nxt    = 1'b1;
      w_bit_cnt_nxt = '0;
      w_state_nxt   = ST_SHIFT;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_mosi    <= MOSI_IDLE;
      r_cs_n    <= CS_N_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign SCLK      = w_sclk;
  assign MOSI      = r_mosi;
  assign CS_N      = r_cs_n;
  assign Busy      = r_busy;
  assign FrameDone = r_done;

endmodule

// File: tb/tb_display_link_tx.sv
// Directed/randomized bench for display_link_tx with an SPI slave monitor as reference.
module tb_display_link_tx;

  localparam int unsigned DBS       = 256;
  localparam int unsigned CD        = 4;
  localparam int unsigned FG        = 16;
  localparam int          FRAME_LEN = 2 * CD * DBS;

  logic           clk = 1'b0;
  logic           RESET;
  logic           Enable;
  logic [DBS-1:0] DisplayBuffer;
  logic           SCLK, MOSI, CS_N, Busy, FrameDone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_link_tx #(
    .DisplayBufferSize (DBS),
    .ClkDiv            (CD),
    .FrameGap          (FG)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .DisplayBuffer (DisplayBuffer),
    .Enable        (Enable),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .CS_N          (CS_N),
    .Busy          (Busy),
    .FrameDone     (FrameDone)
  );

  // Slave-side monitor: samples MOSI on SCLK rise, records every CS_N-low window and gap.
  logic           prev_cs   = 1'b1;
  logic           prev_sclk = 1'b0;
  logic           prev_done = 1'b0;
  logic [DBS-1:0] cur_cap   = '0;
  int             cur_nbits = 0;
  int             cur_len   = 0;
  int             gap_run   = 0;
  bit             have_frame = 1'b0;
  int             done_total = 0;
  int             done_wide  = 0;
  logic [DBS-1:0] cap_q[$];
  int             nbits_q[$];
  int             len_q[$];
  bit             done_q[$];
  int             gap_q[$];

  always @(negedge clk) begin
    if (CS_N === 1'b0) begin
      if (prev_cs) begin
        if (have_frame) gap_q.push_back(gap_run);
        cur_len   = 1;
        cur_nbits = 0;
        cur_cap   = '0;
      end else begin
        cur_len++;
      end
      if (SCLK === 1'b1 && !prev_sclk) begin
        cur_cap = {cur_cap[DBS-2:0], MOSI};
        cur_nbits++;
      end
    end else begin
      if (!prev_cs) begin
        cap_q.push_back(cur_cap);
        nbits_q.push_back(cur_nbits);
        len_q.push_back(cur_len);
        done_q.push_back(FrameDone === 1'b1);
        have_frame = 1'b1;
        gap_run    = 1;
      end else begin
        gap_run++;
      end
    end
    if (FrameDone === 1'b1) begin
      if (prev_done) done_wide++;
      else done_total++;
    end
    prev_cs   = (CS_N !== 1'b0);
    prev_sclk = (SCLK === 1'b1);
    prev_done = (FrameDone === 1'b1);
  end

  task automatic chk(input string tag, input logic [DBS-1:0] obs, input logic [DBS-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DBS-1:0] rnd();
    logic [DBS-1:0] r;
    for (int i = 0; i < DBS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic wait_frames(input int target, input string tag);
    int b = 0;
    while (cap_q.size() < target && b < 3 * FRAME_LEN) begin
      tick();
      b++;
    end
    chk(tag, DBS'(cap_q.size() >= target), DBS'(1));
  endtask

  task automatic wait_cs_low(input string tag);
    int b = 0;
    while (CS_N !== 1'b0 && b < 3 * FRAME_LEN) begin
      tick();
      b++;
    end
    chk(tag, DBS'(CS_N), DBS'(0));
  endtask

  task automatic wait_bits(input int n, input string tag);
    int b = 0;
    while (!(CS_N === 1'b0 && cur_nbits >= n) && b < 3 * FRAME_LEN) begin
      tick();
      b++;
    end
    chk(tag, DBS'(cur_nbits >= n), DBS'(1));
  endtask

  task automatic wait_len(input int n, input string tag);
    int b = 0;
    while (!(CS_N === 1'b0 && cur_len >= n) && b < 3 * FRAME_LEN) begin
      tick();
      b++;
    end
    chk(tag, DBS'(cur_len >= n), DBS'(1));
  endtask

  task automatic chk_frame(input int idx, input logic [DBS-1:0] exp, input string tag);
    chk({tag, "_bits"}, cap_q[idx], exp);
    chk({tag, "_nbits"}, DBS'(nbits_q[idx]), DBS'(DBS));
    chk({tag, "_len"}, DBS'(len_q[idx]), DBS'(FRAME_LEN));
    chk({tag, "_done"}, DBS'(done_q[idx]), DBS'(1));
  endtask

  logic [DBS-1:0] pat, orig, r1, r2, r3;
  int n, d0, w0, bad;

  initial begin
    pat           = {4{64'h0123456789ABCDEF}};
    RESET         = 1'b0;
    Enable        = 1'b1;
    DisplayBuffer = pat;

    // Reset held with Enable high: all outputs idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_idle", DBS'({SCLK, MOSI, CS_N, Busy, FrameDone}), DBS'(5'b00100));
    end
    RESET = 1'b1;
    tick();
    chk("first_load", DBS'({CS_N, Busy, MOSI}), DBS'({1'b0, 1'b1, pat[DBS-1]}));
    Enable = 1'b0;

    // Single frame of the fixed pattern.
    wait_frames(1, "t2_wait");
    chk_frame(0, pat, "t2");
    chk("t2_done_once", DBS'(done_total), DBS'(1));
    chk("t2_done_width", DBS'(done_wide), DBS'(0));

    // Snapshot: buffer changes mid-frame only affect the next frame.
    orig          = rnd();
    DisplayBuffer = orig;
    Enable        = 1'b1;
    n             = cap_q.size();
    wait_bits(100, "t3_bit100");
    DisplayBuffer = '1;
    wait_frames(n + 1, "t3_wait_a");
    wait_cs_low("t3_start_b");
    Enable = 1'b0;
    wait_frames(n + 2, "t3_wait_b");
    chk_frame(n, orig, "t3a");
    chk_frame(n + 1, '1, "t3b");
    chk("t3_gap", DBS'(gap_q[$]), DBS'(FG));

    // Continuous: three back-to-back frames with fresh random contents.
    r1 = rnd(); r2 = rnd(); r3 = rnd();
    DisplayBuffer = r1;
    Enable        = 1'b1;
    n             = cap_q.size();
    wait_cs_low("t4_start_1");
    gap_q.delete();
    d0 = done_total;
    w0 = done_wide;
    DisplayBuffer = r2;
    wait_frames(n + 1, "t4_wait_1");
    wait_cs_low("t4_start_2");
    DisplayBuffer = r3;
    wait_frames(n + 2, "t4_wait_2");
    wait_cs_low("t4_start_3");
    Enable = 1'b0;
    wait_frames(n + 3, "t4_wait_3");
    chk_frame(n, r1, "t4f1");
    chk_frame(n + 1, r2, "t4f2");
    chk_frame(n + 2, r3, "t4f3");
    chk("t4_ngaps", DBS'(gap_q.size()), DBS'(2));
    chk("t4_gap0", DBS'(gap_q[0]), DBS'(FG));
    chk("t4_gap1", DBS'(gap_q[1]), DBS'(FG));
    chk("t4_done_cnt", DBS'(done_total - d0), DBS'(3));
    chk("t4_done_width", DBS'(done_wide - w0), DBS'(0));

    // Enable drop early in a frame: frame still completes, then stays idle.
    r1            = rnd();
    DisplayBuffer = r1;
    Enable        = 1'b1;
    n             = cap_q.size();
    wait_bits(10, "t5_bit10");
    Enable = 1'b0;
    wait_frames(n + 1, "t5_wait");
    chk_frame(n, r1, "t5");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (CS_N !== 1'b1 || SCLK !== 1'b0 || Busy !== 1'b0) bad++;
    end
    chk("t5_idle_after", DBS'(bad), DBS'(0));
    chk("t5_no_new_frame", DBS'(cap_q.size()), DBS'(n + 1));

    // Reset at cycle 500 of a frame aborts it; a fresh frame follows release.
    DisplayBuffer = rnd();
    Enable        = 1'b1;
    n             = cap_q.size();
    wait_len(500, "t6_cycle500");
    RESET = 1'b0;
    tick();
    chk("t6_abort_outs", DBS'({CS_N, SCLK, Busy, FrameDone, MOSI}), DBS'(5'b10000));
    chk("t6_abort_rec", DBS'(cap_q.size()), DBS'(n + 1));
    chk("t6_abort_nodone", DBS'(done_q[n]), DBS'(0));
    chk("t6_abort_short", DBS'(nbits_q[n] < DBS), DBS'(1));
    r2            = rnd();
    DisplayBuffer = r2;
    tick();
    RESET = 1'b1;
    tick();
    chk("t6_restart", DBS'({CS_N, Busy, MOSI}), DBS'({1'b0, 1'b1, r2[DBS-1]}));
    Enable = 1'b0;
    wait_frames(n + 2, "t6_wait");
    chk_frame(n + 1, r2, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_link_tx.md
Name: display_link_tx

Overview:
- Reader end of the processor's DisplayBuffer output.
- Snapshots the full buffer once per frame and streams it serially, MSB first, over a mode-0 SPI-style link (SCLK/MOSI/CS_N) to an external character/segment display controller.
- Sits beside the Processor at top level, same clock domain, and is fed directly from DisplayBuffer.
- Frames repeat while Enable is held, with a fixed idle gap between frames.

Parameters:
- DisplayBufferSize, 256: width of DisplayBuffer in bits. Must be a multiple of 8 and at least 8.
- ClkDiv, 4: clk cycles per SCLK half-period. Must be at least 1.
- FrameGap, 16: clk cycles CS_N is held high between back-to-back frames. Must be at least 1.

Ports:
- clk  input  1  global clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset).
- DisplayBuffer  input  DisplayBufferSize  display contents from Processor.
- Enable  input  1  level; 1 = transmit frames continuously.
- SCLK  output  1  serial clock, idle low.
- MOSI  output  1  serial data; changes only while SCLK is low; slave samples on SCLK rise.
- CS_N  output  1  frame select, active low.
- Busy  output  1  high while CS_N is low.
- FrameDone  output  1  one-cycle pulse at frame end.

Behaviour:
- All outputs are registered.
- Reset (RESET sampled 0): SCLK=0, MOSI=0, CS_N=1, Busy=0, FrameDone=0, state IDLE, all counters 0. Reset mid-frame aborts the frame at that edge; no FrameDone is issued.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If Enable is sampled 1 at edge n: at that edge shadow <= DisplayBuffer, MOSI <= DisplayBuffer[DisplayBufferSize-1], CS_N <= 0, Busy <= 1, bit counter <= 0, divider <= 0, go to SHIFT.
  - CS_N is therefore low after edge n (1-cycle latency).
- SHIFT:
  - Divider counts 0..ClkDiv-1. At terminal count SCLK toggles and the divider wraps.
  - On each SCLK 1->0 toggle:
    - If bit counter = DisplayBufferSize-1: this is the frame end. CS_N <= 1, Busy <= 0, MOSI <= 0, FrameDone <= 1 for one cycle, go to GAP.
    - Otherwise: shadow shifts left by 1, MOSI <= new shadow MSB, bit counter increments.
  - CS_N is low for exactly 2*ClkDiv*DisplayBufferSize cycles (2048 at defaults).
  - Transmission is MSB-first: DisplayBuffer[255] first, DisplayBuffer[0] last.
  - Changes to DisplayBuffer during SHIFT are ignored; only the shadow copy is transmitted, so there is no tearing.
  - Enable deassertion during SHIFT does not truncate the frame.
- GAP:
  - Counts FrameGap cycles with CS_N high and SCLK low.
  - On the last gap cycle, Enable is sampled. If 1, perform the IDLE load action directly, so CS_N is high for exactly FrameGap cycles between frames. If 0, go to IDLE.
- Simultaneous events:
  - Reset has priority over everything.
  - Enable is sampled only in IDLE and on the last GAP cycle.
- Width rules:
  - Bit counter width is clog2(DisplayBufferSize).
  - Divider width is clog2(ClkDiv)+1.
  - Gap counter width is clog2(FrameGap)+1.
  - No counter wraps except the divider.

Decomposition:
- Shared package display_link_pkg: state encoding constants (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the SPI idle levels.
- Sub-module display_link_baud: ClkDiv counter producing a one-cycle tick and the SCLK toggle. It has a clear input driven on frame load and on reset.
- The FSM, shadow register, bit counter and gap counter stay in display_link_tx.

Test Plan:
1. Reset: hold RESET=0 for 3 cycles with Enable=1 -> SCLK=0, MOSI=0, CS_N=1, Busy=0, FrameDone=0 throughout; the first frame starts the cycle after release.
2. Single frame: DisplayBuffer = 256'h0123456789ABCDEF repeated 4 times, Enable pulsed 1 cycle, slave model samples MOSI on SCLK rise -> 256 captured bits equal the buffer MSB-first. CS_N is low for 2048 cycles, with 256 SCLK rising edges. FrameDone pulses once as CS_N rises.
3. Snapshot: change DisplayBuffer to all-ones at bit 100 of a frame -> that frame still captures the original pattern; the next frame (Enable held) captures 256'hFF..FF.
4. Continuous: Enable held 1 for 3 frames with FrameGap=16 -> CS_N high for exactly 16 cycles between frames; FrameDone pulses exactly 3 times, each 1 cycle wide.
5. Enable drop: deassert Enable at bit 10 -> the frame completes all 256 bits, then IDLE with CS_N=1 and SCLK=0 indefinitely.
6. Mid-frame reset: RESET=0 at cycle 500 of a frame -> at the next edge CS_N=1, SCLK=0, no FrameDone. After release with Enable=1, a fresh frame begins at DisplayBuffer[255].
